// File: rtl/cont_dato_if.sv
`default_nettype none
// ============================================================================
//  Module      : cont_dato_if
//  Description : Control/data bundle for one editable time/date field counter.
//                master = field controller side, slave = counter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface cont_dato_if #(
  parameter int WIDTH = 7
) ();
  logic             en;
  logic             aum;
  logic             dism;
  logic             ld;
  logic [WIDTH-1:0] ld_dat;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] dat_sal;
  logic [7:0]       dat_bcd;
  logic             carry;
  logic             borrow;

  modport master (
    output en, aum, dism, ld, ld_dat, max_val,
    input  dat_sal, dat_bcd, carry, borrow
  );

  modport slave (
    input  en, aum, dism, ld, ld_dat, max_val,
    output dat_sal, dat_bcd, carry, borrow
  );
endinterface
`default_nettype wire

// File: rtl/cont_dato_mod.sv
`default_nettype none
// ============================================================================
//  Module      : cont_dato_mod
//  Description : Up/down field counter with runtime upper bound, parallel
//                load, clamp, edge stepping with hold-to-repeat, BCD output
//                and carry/borrow pulses for cascading.
//  Revision    : 1.0  initial release
// ============================================================================
module cont_dato_mod #(
  parameter int WIDTH        = 7,
  parameter int MIN_VAL      = 0,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  cont_dato_if.slave bus
);

  localparam int c_TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  localparam logic [WIDTH-1:0]   c_MIN     = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]   c_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0]   c_TEN     = WIDTH'(10);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE = c_TMR_W'(1);
  localparam logic [c_TMR_W-1:0] c_DELAY   = c_TMR_W'(REPEAT_DELAY);
  localparam logic [c_TMR_W-1:0] c_RATE    = c_TMR_W'(REPEAT_RATE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_TMR_W-1:0] r_timer, w_timer_nxt;
  logic               r_dir, w_dir_nxt;       // 1 = counting up
  logic [WIDTH-1:0]   r_dat, w_dat_nxt;
  logic               r_carry, w_carry_nxt;
  logic               r_borrow, w_borrow_nxt;

  logic               r_aum_q, r_aum_qq;
  logic               r_dism_q, r_dism_qq;
  logic [1:0]         r_vld;                  // both edge stages hold real samples

  logic               w_up_edge, w_dn_edge, w_release;
  logic               w_step, w_step_up;
  logic [WIDTH-1:0]   w_ld_sat;
  logic [3:0]         w_tens, w_ones;

  // Button level sampling; keeps running regardless of en/ld so that a button
  // already held when the field becomes active is not seen as a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aum_q   <= 1'b0;
      r_aum_qq  <= 1'b0;
      r_dism_q  <= 1'b0;
      r_dism_qq <= 1'b0;
      r_vld     <= 2'b00;
    end else begin
      r_aum_q   <= bus.aum;
      r_aum_qq  <= r_aum_q;
      r_dism_q  <= bus.dism;
      r_dism_qq <= r_dism_q;
      r_vld     <= {r_vld[0], 1'b1};
    end
  end

  // Edges are only trusted once the previous-sample stage holds a real
  // sample, so a button held through reset needs a release and re-press.
  assign w_up_edge = r_vld[1] & r_aum_q  & ~r_aum_qq  & ~r_dism_q;
  assign w_dn_edge = r_vld[1] & r_dism_q & ~r_dism_qq & ~r_aum_q;
  assign w_release = (r_aum_q & r_dism_q) | (r_dir ? ~r_aum_q : ~r_dism_q);

  assign w_ld_sat = (bus.ld_dat < c_MIN)       ? c_MIN :
                    (bus.ld_dat > bus.max_val) ? bus.max_val : bus.ld_dat;

  // Step FSM and counter next-value, in priority order load/hold/clamp/step.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_dir_nxt    = r_dir;
    w_step       = 1'b0;
    w_step_up    = r_dir;
    w_dat_nxt    = r_dat;
    w_carry_nxt  = 1'b0;
    w_borrow_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_up_edge) begin
          w_step      = 1'b1;
          w_step_up   = 1'b1;
          w_dir_nxt   = 1'b1;
          w_timer_nxt = c_TMR_ONE;
          w_state_nxt = S_DELAY;
        end else if (w_dn_edge) begin
          w_step      = 1'b1;
          w_step_up   = 1'b0;
          w_dir_nxt   = 1'b0;
          w_timer_nxt = c_TMR_ONE;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY: begin
        if (w_release) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (r_timer == c_DELAY) begin
          w_step      = 1'b1;
          w_timer_nxt = c_TMR_ONE;
          w_state_nxt = S_REPEAT;
        end else begin
          w_timer_nxt = r_timer + c_TMR_ONE;
        end
      end
      S_REPEAT: begin
        if (w_release) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (r_timer == c_RATE) begin
          w_step      = 1'b1;
          w_timer_nxt = c_TMR_ONE;
        end else begin
          w_timer_nxt = r_timer + c_TMR_ONE;
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    if (bus.ld) begin
      w_dat_nxt   = w_ld_sat;
      w_timer_nxt = '0;
      w_state_nxt = S_IDLE;
    end else if (!bus.en) begin
      w_timer_nxt = '0;
      w_state_nxt = S_IDLE;
    end else if (r_dat > bus.max_val) begin
      // Bound shrank under the current value: pull down, suppress the step.
      w_dat_nxt = bus.max_val;
    end else if (w_step) begin
      if (w_step_up) begin
        if (r_dat == bus.max_val) begin
          w_dat_nxt   = c_MIN;
          w_carry_nxt = 1'b1;
        end else begin
          w_dat_nxt = r_dat + c_ONE;
        end
      end else begin
        if (r_dat == c_MIN) begin
          w_dat_nxt    = bus.max_val;
          w_borrow_nxt = 1'b1;
        end else begin
          w_dat_nxt = r_dat - c_ONE;
        end
      end
    end
  end

  // State, timer, counter value and wrap pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_dir    <= 1'b1;
      r_dat    <= c_MIN;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_dir    <= w_dir_nxt;
      r_dat    <= w_dat_nxt;
      r_carry  <= w_carry_nxt;
      r_borrow <= w_borrow_nxt;
    end
  end

  assign w_tens = 4'(r_dat / c_TEN);
  assign w_ones = 4'(r_dat % c_TEN);

  assign bus.dat_sal = r_dat;
  assign bus.dat_bcd = {w_tens, w_ones};
  assign bus.carry   = r_carry;
  assign bus.borrow  = r_borrow;

endmodule
`default_nettype wire

// File: doc/cont_dato_mod.md
# cont_dato_mod

Parametrised up/down data counter for the time/date setting path: each instance holds one editable field (seconds, minutes, hours, day, month, year) and steps it from debounced button levels. Generalises the fixed 0–99 counter with a runtime-selectable upper bound, a parameterised lower bound, and on-edge stepping with hold-to-repeat. It also adds parallel load from the RTC read path, BCD output and carry/borrow pulses for cascading.

## Interface
- WIDTH, 7: counter width; MAX_VAL ≤ 2^WIDTH−1.
- MIN_VAL, 0: lower bound (1 for day/month fields).
- REPEAT_DELAY, 50_000_000: cycles a button must be held after its edge before the first auto-repeat step; ≥2.
- REPEAT_RATE, 10_000_000: cycles between subsequent auto-repeat steps; ≥1.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  field selected for editing; low = hold.
- aum  in  1  increment button level (already debounced).
- dism  in  1  decrement button level (already debounced).
- ld  in  1  parallel load strobe.
- ld_dat  in  WIDTH  load value.
- max_val  in  WIDTH  current upper bound, e.g. 28/29/30/31 for days; must be ≥ MIN_VAL.
- dat_sal  out  WIDTH  counter value, registered.
- dat_bcd  out  8  {tens, ones} BCD of dat_sal; valid for dat_sal ≤ 99.
- carry  out  1  one-cycle pulse on wrap max_val→MIN_VAL.
- borrow  out  1  one-cycle pulse on wrap MIN_VAL→max_val.

## Operation
- Reset (reset=0): dat_sal=MIN_VAL, dat_bcd=BCD(MIN_VAL), carry=borrow=0, FSM=IDLE, edge registers=0, timer=0.
- Per-cycle priority:
  1. ld
  2. en=0
  3. clamp
  4. step
  5. hold
- ld=1: dat_sal ← ld_dat saturated to [MIN_VAL, max_val]. Works regardless of en. No carry/borrow. FSM → IDLE.
- en=0: dat_sal holds. FSM → IDLE, timer cleared. Edge registers keep sampling, so enabling while a button is held produces no step.
- Clamp: if dat_sal > max_val, dat_sal ← max_val. No step that cycle, no pulse.
- Step up: dat_sal = max_val → MIN_VAL with carry=1; otherwise +1.
- Step down: dat_sal = MIN_VAL → max_val with borrow=1; otherwise −1.
- Arithmetic is WIDTH bits unsigned; the wrap compare always uses the live max_val.
- Step FSM, with edges from aum_q/dism_q registered copies:
  - IDLE: aum rising with dism=0 → step up, dir=up, timer=1, → DELAY. dism rising with aum=0 → step down, dir=down, → DELAY.
  - DELAY: button of dir still held alone → timer++. On timer=REPEAT_DELAY: step, timer=1, → REPEAT.
  - REPEAT: on timer=REPEAT_RATE: step, timer=1; otherwise timer++.
  - Any state: button of dir released, or both buttons high → IDLE, timer=0, no step.
- Both aum and dism high: never steps. Release of one while the other stays high is not an edge; it requires release and re-press.
- dat_bcd is derived combinationally from the registered dat_sal (tens = value/10, ones = value%10). It carries no extra latency.

## Timing
- Edge latency: aum rises in cycle t (sampled at edge t) → dat_sal updated at edge t+1. carry/borrow are asserted in the same cycle as the wrapped value.
- Held button: the k-th auto step (k≥1) takes effect at edge t+1+REPEAT_DELAY+(k−1)·REPEAT_RATE.
- ld: dat_sal = saturated ld_dat one edge after ld sampled high.
- Clamp: one edge after max_val drops below dat_sal, with en=1.
- Reset assertion mid-repeat: outputs return to reset values immediately (asynchronous). The first step after deassertion needs a fresh rising edge.

## Test plan
Test parameters: WIDTH=7, MIN_VAL=1, REPEAT_DELAY=4, REPEAT_RATE=2, max_val=31.
- Reset, then en=1; pulse aum for 1 cycle, three times → dat_sal 1→2→3→4; dat_bcd=0x04; carry never high.
- ld=1, ld_dat=31; then one aum pulse → dat_sal=1, carry high exactly 1 cycle. Then one dism pulse → dat_sal=31, borrow high 1 cycle.
- Hold aum 12 cycles from dat_sal=5 → steps at edges t+1, t+5, t+7, t+9, t+11, t+13 (the last only if still held); value 5→10 after release at t+12 (edge t+13 not reached).
- dat_sal=31, set max_val=28 with en=1 → dat_sal=28 one edge later, no carry. ld_dat=0 → dat_sal=1; ld_dat=99 → dat_sal=28.
- en=0 while aum pulsed → dat_sal unchanged. Raise en with aum held high → no step until release and re-press. aum and dism both high 10 cycles → no change.
- Hold aum in REPEAT, assert reset=0 for 1 cycle mid-hold → dat_sal=1 immediately, carry=0; continued hold after release of reset → no step.
